store_unit: RTL
===============

Name: store_unit

Overview:
- Write-side counterpart of the load path: takes a store request (sb/sh/sw) from the execute stage and issues byte-lane-masked word writes to data memory over a req/ack handshake.
- Aligns the store data into the correct byte lanes and produces the byte enables.
- Splits misaligned halfword/word stores that cross a word boundary into two word-aligned beats.
- Sits between the core datapath and the data memory port.

Parameters:
- SPLIT_MISALIGNED, 1, 1 = cross-word stores are split into two beats; 0 = they are rejected with storeError.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- storeValid  input  1  store request present.
- storeReady  output  1  unit can accept a request; high only in IDLE.
- storeSrc  input  3  store size: 3'b000 sb, 3'b001 sh, 3'b010 sw; any other code is illegal.
- storeAddress  input  32  byte address.
- storeData  input  32  rs2 value; the low 8/16/32 bits are used.
- memReq  output  1  write beat valid.
- memAck  input  1  memory accepted the beat.
- memAddress  output  32  word-aligned beat address, low 2 bits always 0.
- memWriteData  output  32  lane-aligned data; disabled lanes are 0.
- memByteEnable  output  4  per-lane write enable; bit i covers bits [8i+7:8i].
- storeDone  output  1  one-cycle pulse: request retired.
- storeError  output  1  one-cycle pulse, coincident with storeDone: request rejected, nothing written.

Behaviour:
- Reset: state IDLE; memReq, storeDone and storeError = 0; memAddress, memWriteData and memByteEnable = 0; storeReady = 1 from the cycle after reset deasserts.
- Reset mid-operation abandons any in-flight store. memReq is low the cycle after the reset edge. The memory side must tolerate a withdrawn request.
- Accept: when storeValid && storeReady at a clock edge, all inputs are captured. storeAddress, storeData and storeSrc may change afterwards.
- Alignment math, with off = addr[1:0] and n = 1, 2 or 4 bytes:
  - mask8 = ((1<<n)-1) << off
  - data64 = {32'b0, data masked to n bytes} << (8*off)
  - Beat 1: address {addr[31:2], 2'b00}, byte enable mask8[3:0], data data64[31:0].
  - Beat 2: exists iff mask8[7:4] != 0. Address is beat 1 address + 4, wrapping modulo 2^32. Byte enable mask8[7:4], data data64[63:32].
- FSM states: IDLE, BEAT1, BEAT2, FINISH.
  - IDLE -> BEAT1 on accept of a legal request that is aligned or splittable.
  - IDLE -> FINISH with the error flag set on an illegal storeSrc, or on a cross-word store when SPLIT_MISALIGNED = 0. No memReq is issued.
  - BEAT1 -> BEAT2 on memAck when beat 2 exists; otherwise BEAT1 -> FINISH on memAck.
  - BEAT2 -> FINISH on memAck.
  - FINISH -> IDLE unconditionally.
- FINISH outputs: storeDone = 1, storeError = error flag, storeReady = 0.
- memReq is high throughout BEAT1 and BEAT2. memAddress, memWriteData and memByteEnable are registered and held stable until memAck.
- An ack in the same cycle memReq rises completes that beat.
- memAck is ignored while memReq is low.
- Latency with zero-wait memory:
  - Accept edge, then memReq high for 1 cycle per beat, then a 1-cycle FINISH.
  - Aligned store: done pulse 2 cycles after accept; next accept possible the cycle after FINISH.
- Beat ordering is fixed: low word first, then high word. Partial completion on reset is not rolled back.

Decomposition:
- store_pkg holds:
  - storeSrc codes: STORE_SB, STORE_SH, STORE_SW.
  - typedef enum for the FSM states.
  - A function returning the byte count for a storeSrc.
- Sub-module store_lane_align is purely combinational. Inputs: storeSrc, storeAddress[1:0], storeData. Outputs: 8-bit mask, 64-bit shifted data, crossWord flag, illegal flag.
- store_unit holds the FSM, the capture registers and the beat-2 address increment.

Test Plan:
- sb, address 0x00001003, data 0x000000AB, memAck tied high -> one beat: memAddress 0x00001000, BE 4'b1000, data 0xAB000000; storeDone pulses 2 cycles after accept.
- sh, address 0x00002002, data 0xFFFF1234 -> one beat: memAddress 0x00002000, BE 4'b1100, data 0x12340000.
- sw, address 0x00003001, data 0xDEADBEEF, SPLIT_MISALIGNED = 1 -> beat 1: 0x00003000, BE 4'b1110, data 0xADBEEF00; beat 2: 0x00003004, BE 4'b0001, data 0x000000DE. Same store with SPLIT_MISALIGNED = 0 -> no memReq; storeError and storeDone pulse.
- sh, address 0xFFFFFFFF, data 0x0000CAFE -> beat 1: 0xFFFFFFFC, BE 4'b1000, data 0xFE000000; beat 2 wraps to 0x00000000, BE 4'b0001, data 0x000000CA.
- storeSrc 3'b011 -> memReq never asserted; storeError = storeDone = 1 for exactly one cycle; storeReady returns high the following cycle.
- memAck held low 5 cycles during an sw to 0x00000010 -> memReq, address, data and BE stable all 5 cycles. Then assert reset during BEAT1 of a split store -> memReq = 0 after the reset edge, no storeDone pulse, storeReady = 1 after reset is released.

Source files
------------

// File: rtl/store_pkg.sv
// Shared definitions for the store path: size codes, FSM states and the
// byte-count helper used by the lane aligner.
package store_pkg;

    localparam logic [2:0] STORE_SB = 3'b000;
    localparam logic [2:0] STORE_SH = 3'b001;
    localparam logic [2:0] STORE_SW = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT1,
        ST_BEAT2,
        ST_FINISH
    } store_state_t;

    // Zero marks an illegal size code.
    function automatic logic [2:0] store_bytes(input logic [2:0] src);
        case (src)
            STORE_SB: store_bytes = 3'd1;
            STORE_SH: store_bytes = 3'd2;
            STORE_SW: store_bytes = 3'd4;
            default:  store_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational byte-lane aligner: places the store data and its byte mask
// across a two-word window starting at the word containing the address.
module store_lane_align
    import store_pkg::*;
(
    input  logic [2:0]  storeSrc,
    input  logic [1:0]  addrLow,
    input  logic [31:0] storeData,
    output logic [7:0]  mask,
    output logic [63:0] data64,
    output logic        crossWord,
    output logic        illegal
);

    logic [2:0]  nbytes;
    logic [7:0]  lowMask;
    logic [31:0] sizedData;

    always_comb begin
        nbytes    = store_bytes(storeSrc);
        lowMask   = 8'h00;
        sizedData = 32'h0;
        case (nbytes)
            3'd1: begin
                lowMask   = 8'h01;
                sizedData = {24'h0, storeData[7:0]};
            end
            3'd2: begin
                lowMask   = 8'h03;
                sizedData = {16'h0, storeData[15:0]};
            end
            3'd4: begin
                lowMask   = 8'h0F;
                sizedData = storeData;
            end
            default: begin
                lowMask   = 8'h00;
                sizedData = 32'h0;
            end
        endcase
        mask      = lowMask << addrLow;
        data64    = {32'h0, sizedData} << {addrLow, 3'b000};
        crossWord = |mask[7:4];
        illegal   = (nbytes == 3'd0);
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: captures a store request, issues one or two byte-masked word
// writes over a req/ack handshake, then pulses storeDone (and storeError).
module store_unit
    import store_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        storeValid,
    output logic        storeReady,
    input  logic [2:0]  storeSrc,
    input  logic [31:0] storeAddress,
    input  logic [31:0] storeData,
    output logic        memReq,
    input  logic        memAck,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic [3:0]  memByteEnable,
    output logic        storeDone,
    output logic        storeError
);

    store_state_t state;

    logic [7:0]  mask;
    logic [63:0] data64;
    logic        crossWord;
    logic        illegal;
    logic [3:0]  hiByteEnable;
    logic [31:0] hiWriteData;

    store_lane_align u_align (
        .storeSrc  (storeSrc),
        .addrLow   (storeAddress[1:0]),
        .storeData (storeData),
        .mask      (mask),
        .data64    (data64),
        .crossWord (crossWord),
        .illegal   (illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            storeReady    <= 1'b0;
            memReq        <= 1'b0;
            memAddress    <= 32'h0;
            memWriteData  <= 32'h0;
            memByteEnable <= 4'h0;
            storeDone     <= 1'b0;
            storeError    <= 1'b0;
            hiByteEnable  <= 4'h0;
            hiWriteData   <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    storeReady <= 1'b1;
                    storeDone  <= 1'b0;
                    storeError <= 1'b0;
                    if (storeValid && storeReady) begin
                        storeReady <= 1'b0;
                        if (illegal || (crossWord && !SPLIT_MISALIGNED)) begin
                            state      <= ST_FINISH;
                            storeDone  <= 1'b1;
                            storeError <= 1'b1;
                        end else begin
                            // High half of the window is kept for a possible second beat.
                            state         <= ST_BEAT1;
                            memReq        <= 1'b1;
                            memAddress    <= {storeAddress[31:2], 2'b00};
                            memByteEnable <= mask[3:0];
                            memWriteData  <= data64[31:0];
                            hiByteEnable  <= mask[7:4];
                            hiWriteData   <= data64[63:32];
                        end
                    end
                end
                ST_BEAT1: begin
                    if (memAck) begin
                        if (hiByteEnable != 4'h0) begin
                            state         <= ST_BEAT2;
                            memAddress    <= memAddress + 32'd4;
                            memByteEnable <= hiByteEnable;
                            memWriteData  <= hiWriteData;
                        end else begin
                            state     <= ST_FINISH;
                            memReq    <= 1'b0;
                            storeDone <= 1'b1;
                        end
                    end
                end
                ST_BEAT2: begin
                    if (memAck) begin
                        state     <= ST_FINISH;
                        memReq    <= 1'b0;
                        storeDone <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state      <= ST_IDLE;
                    storeDone  <= 1'b0;
                    storeError <= 1'b0;
                    storeReady <= 1'b1;
                end
                default: begin
                    state      <= ST_IDLE;
                    memReq     <= 1'b0;
                    storeDone  <= 1'b0;
                    storeError <= 1'b0;
                    storeReady <= 1'b0;
                end
            endcase
        end
    end

endmodule
